collision_arbiter: RTL

Parametrised per-frame collision arbiter for the VGA game. It compares the per-pixel drawing requests of the player, the alien block, N player rockets, M alien rockets and B bonus objects. Each collision is reported as a single-cycle registered pulse, at most once per object per frame. It also adds a frame-counted invulnerability window after a player hit, a god-mode override, and a per-frame hit tally. It sits between the object drawers and the game state / score / rocket logic, and replaces the ad-hoc combinational collision checks.

---
 rtl/collision_arbiter_if.sv | 41 ++++
 rtl/collision_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/collision_arbiter_if.sv
// Signal bundle between the object drawers, the collision arbiter and the game-state logic.
// The master side drives drawing requests and frame timing; the slave side reports collisions.
interface collision_arbiter_if #(
  parameter int P_ROCKETS = 2,
  parameter int A_ROCKETS = 3,
  parameter int BONUSES   = 2,
  parameter int CNT_W     = 4
);
  logic                 startOfFrame;
  logic signed [10:0]   pixelY;
  logic                 dr_player;
  logic                 dr_aliens;
  logic [P_ROCKETS-1:0] dr_procket;
  logic [A_ROCKETS-1:0] dr_arocket;
  logic [BONUSES-1:0]   dr_bonus;
  logic                 godmode_en;

  logic [P_ROCKETS-1:0] alien_hit;
  logic [A_ROCKETS-1:0] arocket_hit_player;
  logic                 player_hit;
  logic [P_ROCKETS-1:0] procket_clash;
  logic [A_ROCKETS-1:0] arocket_clash;
  logic [BONUSES-1:0]   bonus_hit;
  logic                 border_reached;
  logic                 invulnerable;
  logic [CNT_W-1:0]     frame_hits;

  modport master (
    output startOfFrame, pixelY, dr_player, dr_aliens, dr_procket, dr_arocket, dr_bonus,
           godmode_en,
    input  alien_hit, arocket_hit_player, player_hit, procket_clash, arocket_clash,
           bonus_hit, border_reached, invulnerable, frame_hits
  );

  modport slave (
    input  startOfFrame, pixelY, dr_player, dr_aliens, dr_procket, dr_arocket, dr_bonus,
           godmode_en,
    output alien_hit, arocket_hit_player, player_hit, procket_clash, arocket_clash,
           bonus_hit, border_reached, invulnerable, frame_hits
  );
endinterface

// File: rtl/collision_arbiter.sv
// Per-frame collision arbiter: one registered pulse per object per frame, player
// invulnerability window with god-mode override, and a saturating per-frame hit tally.
module collision_arbiter #(
  parameter int P_ROCKETS     = 2,
  parameter int A_ROCKETS     = 3,
  parameter int BONUSES       = 2,
  parameter int BORDER_Y      = 479,
  parameter int INVULN_FRAMES = 30,
  parameter int CNT_W         = 4
) (
  input logic                clk,
  input logic                resetN,
  collision_arbiter_if.slave bus
);
  localparam int INV_W = ($clog2(INVULN_FRAMES + 1) < 1) ? 1 : $clog2(INVULN_FRAMES + 1);
  localparam logic [INV_W-1:0]   INV_LOAD = INV_W'(INVULN_FRAMES);
  localparam logic signed [10:0] BORDER_S = $signed(11'(BORDER_Y));

  function automatic logic [3:0] popcount(input logic [P_ROCKETS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < P_ROCKETS; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W+4:0] s;
    s = {5'b0, a} + {{(CNT_W + 1){1'b0}}, b};
    return (s > {5'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [P_ROCKETS-1:0] alien_raw_p0, pc_raw_p0, alien_nxt_p0, pc_nxt_p0;
  logic [A_ROCKETS-1:0] arh_raw_p0, ac_raw_p0, arh_nxt_p0, ac_nxt_p0;
  logic [BONUSES-1:0]   bonus_raw_p0, bonus_nxt_p0;
  logic                 border_raw_p0, border_nxt_p0, dmg_raw_p0, player_nxt_p0;

  logic [P_ROCKETS-1:0] alien_emsk, pc_emsk;
  logic [A_ROCKETS-1:0] arh_emsk, ac_emsk;
  logic [BONUSES-1:0]   bonus_emsk;
  logic                 border_emsk, dmg_emsk;

  logic [P_ROCKETS-1:0] alien_msk_p1, pc_msk_p1, alien_hit_p1, pc_hit_p1;
  logic [A_ROCKETS-1:0] arh_msk_p1, ac_msk_p1, arh_hit_p1, ac_hit_p1;
  logic [BONUSES-1:0]   bonus_msk_p1, bonus_hit_p1;
  logic                 border_msk_p1, border_hit_p1, dmg_msk_p1, player_hit_p1;

  logic [INV_W-1:0]     inv_cnt_p1;
  logic [CNT_W-1:0]     acc_p1, acc_nxt_p0, frame_hits_p1;
  logic                 invulnerable;

  assign invulnerable = (inv_cnt_p1 != '0) | bus.godmode_en;

  // Stage p0: per-pixel overlap conditions, frame-masked into next-cycle pulses
  always_comb begin
    alien_raw_p0  = bus.dr_procket & {P_ROCKETS{bus.dr_aliens}};
    arh_raw_p0    = bus.dr_arocket & {A_ROCKETS{bus.dr_player}};
    pc_raw_p0     = bus.dr_procket & {P_ROCKETS{|bus.dr_arocket}};
    ac_raw_p0     = bus.dr_arocket & {A_ROCKETS{|bus.dr_procket}};
    bonus_raw_p0  = bus.dr_bonus   & {BONUSES{|bus.dr_procket}};
    border_raw_p0 = bus.dr_aliens & (bus.pixelY > BORDER_S);
    dmg_raw_p0    = (bus.dr_aliens & bus.dr_player) | (|arh_raw_p0);

    alien_emsk  = bus.startOfFrame ? '0 : alien_msk_p1;
    arh_emsk    = bus.startOfFrame ? '0 : arh_msk_p1;
    pc_emsk     = bus.startOfFrame ? '0 : pc_msk_p1;
    ac_emsk     = bus.startOfFrame ? '0 : ac_msk_p1;
    bonus_emsk  = bus.startOfFrame ? '0 : bonus_msk_p1;
    border_emsk = bus.startOfFrame ? 1'b0 : border_msk_p1;
    dmg_emsk    = bus.startOfFrame ? 1'b0 : dmg_msk_p1;

    alien_nxt_p0  = alien_raw_p0 & ~alien_emsk;
    arh_nxt_p0    = arh_raw_p0 & ~arh_emsk;
    pc_nxt_p0     = pc_raw_p0 & ~pc_emsk;
    ac_nxt_p0     = ac_raw_p0 & ~ac_emsk;
    bonus_nxt_p0  = bonus_raw_p0 & ~bonus_emsk;
    border_nxt_p0 = border_raw_p0 & ~border_emsk;
    // Damage mask still latches while invulnerable, so no late hit once protection ends.
    player_nxt_p0 = dmg_raw_p0 & ~dmg_emsk & ~invulnerable;

    acc_nxt_p0 = sat_add(bus.startOfFrame ? '0 : acc_p1, popcount(alien_nxt_p0));
  end

  // Stage p1: registered pulses, seen-this-frame masks, invulnerability and tally
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      alien_msk_p1  <= '0;
      arh_msk_p1    <= '0;
      pc_msk_p1     <= '0;
      ac_msk_p1     <= '0;
      bonus_msk_p1  <= '0;
      border_msk_p1 <= 1'b0;
      dmg_msk_p1    <= 1'b0;
      alien_hit_p1  <= '0;
      arh_hit_p1    <= '0;
      pc_hit_p1     <= '0;
      ac_hit_p1     <= '0;
      bonus_hit_p1  <= '0;
      border_hit_p1 <= 1'b0;
      player_hit_p1 <= 1'b0;
      inv_cnt_p1    <= '0;
      acc_p1        <= '0;
      frame_hits_p1 <= '0;
    end else begin
      alien_msk_p1  <= alien_emsk | alien_raw_p0;
      arh_msk_p1    <= arh_emsk | arh_raw_p0;
      pc_msk_p1     <= pc_emsk | pc_raw_p0;
      ac_msk_p1     <= ac_emsk | ac_raw_p0;
      bonus_msk_p1  <= bonus_emsk | bonus_raw_p0;
      border_msk_p1 <= border_emsk | border_raw_p0;
      dmg_msk_p1    <= dmg_emsk | dmg_raw_p0;
      alien_hit_p1  <= alien_nxt_p0;
      arh_hit_p1    <= arh_nxt_p0;
      pc_hit_p1     <= pc_nxt_p0;
      ac_hit_p1     <= ac_nxt_p0;
      bonus_hit_p1  <= bonus_nxt_p0;
      border_hit_p1 <= border_nxt_p0;
      player_hit_p1 <= player_nxt_p0;
      acc_p1        <= acc_nxt_p0;
      if (bus.startOfFrame) frame_hits_p1 <= acc_p1;
      if (player_hit_p1) inv_cnt_p1 <= INV_LOAD;
      else if (bus.startOfFrame && (inv_cnt_p1 != '0)) inv_cnt_p1 <= inv_cnt_p1 - INV_W'(1);
    end
  end

  assign bus.alien_hit          = alien_hit_p1;
  assign bus.arocket_hit_player = arh_hit_p1;
  assign bus.player_hit         = player_hit_p1;
  assign bus.procket_clash      = pc_hit_p1;
  assign bus.arocket_clash      = ac_hit_p1;
  assign bus.bonus_hit          = bonus_hit_p1;
  assign bus.border_reached     = border_hit_p1;
  assign bus.invulnerable       = invulnerable;
  assign bus.frame_hits         = frame_hits_p1;
endmodule
